// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the iterative mul/div sequencer.
// No timing, no flow control: declarations only.
// Optional fast path elsewhere is controlled by ALU_SEQ_FASTZERO_EN.
package alu_seq_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    OP_MUL   = 2'd0,
    OP_MULHU = 2'd1,
    OP_DIVU  = 2'd2,
    OP_REMU  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_flags.sv
// Carry/borrow recovery from the MSBs of the shared ALU's operands and result.
// Purely combinational, zero latency; no flow control.
// The external ALU exposes only a zero flag, so these are rebuilt here.
module alu_seq_flags (
  input  logic a_msb,
  input  logic b_msb,
  input  logic out_msb,
  output logic carry,
  output logic borrow
);

  assign carry  = (a_msb & b_msb) | ((a_msb | b_msb) & ~out_msb);
  assign borrow = (~a_msb & b_msb) | (~(a_msb ^ b_msb) & out_msb);

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU, one bit per cycle on the shared ALU.
// Latency XLEN+1 cycles (1 with ALU_SEQ_FASTZERO_EN on zero operands).
// No backpressure: start is accepted only in IDLE, ignored while busy.
module alu_muldiv_seq
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [3:0]      alu_ctl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_zero
);

  localparam int CW = $clog2(XLEN);

  state_t          state;
  op_t             op_q;
  logic [CW-1:0]   cnt;
  // hi = P_hi / R, lo = P_lo / Q, m = multiplicand / divisor
  logic [XLEN-1:0] hi, lo, m;

  logic            is_mul, start_mul;
  logic            rhi, ge, carry, borrow, last;
  logic [XLEN-1:0] rs, hi_nxt, lo_nxt;
  logic            unused_zero;

  assign unused_zero = alu_zero;
  assign busy        = (state != S_IDLE);
  assign is_mul      = (op_q == OP_MUL) || (op_q == OP_MULHU);
  assign start_mul   = (op_t'(op) == OP_MUL) || (op_t'(op) == OP_MULHU);
  assign last        = (cnt == CW'(XLEN - 1));

  assign rhi = hi[XLEN-1];
  assign rs  = {hi[XLEN-2:0], lo[XLEN-1]};

  always_comb begin
    alu_ctl = ALU_ADD;
    alu_a   = '0;
    alu_b   = '0;
    if (state == S_RUN) begin
      if (is_mul) begin
        alu_a = hi;
        alu_b = lo[0] ? m : '0;
      end else begin
        alu_ctl = ALU_SUB;
        alu_a   = rs;
        alu_b   = m;
      end
    end
  end

  alu_seq_flags u_flags (
    .a_msb   (alu_a[XLEN-1]),
    .b_msb   (alu_b[XLEN-1]),
    .out_msb (alu_out[XLEN-1]),
    .carry   (carry),
    .borrow  (borrow)
  );

  // rhi set means the shifted remainder already exceeds XLEN bits, so it is >= D
  assign ge = rhi | ~borrow;

  always_comb begin
    if (is_mul) begin
      hi_nxt = {carry, alu_out[XLEN-1:1]};
      lo_nxt = {alu_out[0], lo[XLEN-1:1]};
    end else begin
      hi_nxt = ge ? alu_out : rs;
      lo_nxt = {lo[XLEN-2:0], ge};
    end
  end

`ifdef ALU_SEQ_FASTZERO_EN
  logic            fast_hit;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
    if (start_mul) begin
      fast_hit = (in_a == '0) || (in_b == '0);
    end else begin
      fast_hit = (in_b == '0);
      fast_res = (op_t'(op) == OP_DIVU) ? '1 : in_a;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= OP_MUL;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op_t'(op);
            cnt  <= '0;
            hi   <= '0;
            lo   <= start_mul ? in_b : in_a;
            m    <= start_mul ? in_a : in_b;
`ifdef ALU_SEQ_FASTZERO_EN
            if (fast_hit) begin
              state  <= S_DONE;
              done   <= 1'b1;
              result <= fast_res;
            end else begin
              state <= S_RUN;
            end
`else
            state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            state <= S_DONE;
            done  <= 1'b1;
            case (op_q)
              OP_MUL:   result <= lo_nxt;
              OP_MULHU: result <= hi_nxt;
              OP_DIVU:  result <= lo_nxt;
              OP_REMU:  result <= hi_nxt;
            endcase
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural model of the shared ALU.
// Expected latencies follow ALU_SEQ_FASTZERO_EN when it is defined.
module tb_alu_muldiv_seq;

  localparam int LAT = 33;
`ifdef ALU_SEQ_FASTZERO_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, busy, done, alu_zero;
  logic [1:0]  op;
  logic [31:0] in_a, in_b, result, alu_a, alu_b, alu_out;
  logic [3:0]  alu_ctl;

  int tests = 0;
  int fails = 0;

  alu_muldiv_seq #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .in_a     (in_a),
    .in_b     (in_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .alu_ctl  (alu_ctl),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_out  (alu_out),
    .alu_zero (alu_zero)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_ctl)
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0010: alu_out = alu_a + alu_b;
      4'b0110: alu_out = alu_a - alu_b;
      4'b0111: alu_out = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      4'b1100: alu_out = ~(alu_a | alu_b);
      default: alu_out = 32'd0;
    endcase
  end
  assign alu_zero = (alu_out == 32'd0);

  // Launch one op from IDLE; c=1 is the first cycle after the accept edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int bcnt,
                        output logic [3:0] ctl1);
    @(negedge clk);
    start = 1'b1; op = o; in_a = a; in_b = b;
    @(negedge clk);
    start = 1'b0;
    lat = -1; bcnt = 0; res = 32'd0; ctl1 = 4'd0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 1) ctl1 = alu_ctl;
      if (busy) bcnt++;
      if (done && lat < 0) begin
        lat = c;
        res = result;
      end
      if (lat >= 0 && !busy) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 2'd0; in_a = 32'd0; in_b = 32'd0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (result !== 32'd0) begin fails++; $display("FAIL reset_result got %h want 0", result); end
    tests++; if (alu_ctl !== 4'b0010) begin fails++; $display("FAIL reset_alu_ctl got %b want 0010", alu_ctl); end
    tests++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin
      fails++; $display("FAIL reset_alu_ab got %h/%h want 0/0", alu_a, alu_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul;
    logic [31:0] r; int lat, bc; logic [3:0] c1;
    run_op(2'd0, 32'd7, 32'd6, r, lat, bc, c1);
    tests++; if (r !== 32'd42) begin fails++; $display("FAIL mul_7x6 got %0d want 42", r); end
    tests++; if (lat != LAT) begin fails++; $display("FAIL mul_latency got %0d want %0d", lat, LAT); end
    tests++; if (bc != LAT) begin fails++; $display("FAIL mul_busy_cycles got %0d want %0d", bc, LAT); end
    tests++; if (c1 !== 4'b0010) begin fails++; $display("FAIL mul_alu_ctl got %b want 0010", c1); end
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc, c1);
    tests++; if (r !== 32'hFFFF_FFFE) begin fails++; $display("FAIL mulhu_ones got %h want fffffffe", r); end
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc, c1);
    tests++; if (r !== 32'h0000_0001) begin fails++; $display("FAIL mul_ones got %h want 00000001", r); end
    run_op(2'd1, 32'h0, 32'h5, r, lat, bc, c1);
    tests++; if (r !== 32'd0 || lat != ZLAT) begin
      fails++; $display("FAIL mulhu_zero got %h lat %0d want 0 lat %0d", r, lat, ZLAT);
    end
  endtask

  task automatic test_div;
    logic [31:0] r; int lat, bc; logic [3:0] c1;
    run_op(2'd2, 32'd100, 32'd7, r, lat, bc, c1);
    tests++; if (r !== 32'd14) begin fails++; $display("FAIL divu_100_7 got %0d want 14", r); end
    tests++; if (c1 !== 4'b0110) begin fails++; $display("FAIL divu_alu_ctl got %b want 0110", c1); end
    tests++; if (lat != LAT) begin fails++; $display("FAIL divu_latency got %0d want %0d", lat, LAT); end
    run_op(2'd3, 32'd100, 32'd7, r, lat, bc, c1);
    tests++; if (r !== 32'd2) begin fails++; $display("FAIL remu_100_7 got %0d want 2", r); end
    run_op(2'd2, 32'hFFFF_FFFF, 32'h8000_0000, r, lat, bc, c1);
    tests++; if (r !== 32'd1) begin fails++; $display("FAIL divu_rhi got %h want 00000001", r); end
    run_op(2'd3, 32'hFFFF_FFFF, 32'h8000_0000, r, lat, bc, c1);
    tests++; if (r !== 32'h7FFF_FFFF) begin fails++; $display("FAIL remu_rhi got %h want 7fffffff", r); end
  endtask

  task automatic test_divzero;
    logic [31:0] r; int lat, bc; logic [3:0] c1;
    run_op(2'd2, 32'h1234, 32'd0, r, lat, bc, c1);
    tests++; if (r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divu_by0 got %h want ffffffff", r); end
    tests++; if (lat != ZLAT) begin fails++; $display("FAIL divu_by0_latency got %0d want %0d", lat, ZLAT); end
    run_op(2'd3, 32'h1234, 32'd0, r, lat, bc, c1);
    tests++; if (r !== 32'h1234) begin fails++; $display("FAIL remu_by0 got %h want 00001234", r); end
    tests++; if (lat != ZLAT) begin fails++; $display("FAIL remu_by0_latency got %0d want %0d", lat, ZLAT); end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    start = 1'b1; op = 2'd0; in_a = 32'd3; in_b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      if (c == 5) begin start = 1'b1; op = 2'd2; in_a = 32'd100; in_b = 32'd7; end
      if (c == 6) start = 1'b0;
      if (done) begin lat = c; break; end
      @(negedge clk);
    end
    tests++; if (lat != LAT) begin fails++; $display("FAIL run_start_ignored latency got %0d want %0d", lat, LAT); end
    tests++; if (result !== 32'd12) begin fails++; $display("FAIL run_start_ignored got %0d want 12", result); end
    // start raised in the DONE cycle must be dropped
    start = 1'b1; op = 2'd0; in_a = 32'd2; in_b = 32'd2;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL done_start_ignored busy got %b want 0", busy); end
    tests++; if (result !== 32'd12) begin fails++; $display("FAIL done_start_result got %0d want 12", result); end
    in_a = 32'd5; in_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL idle_start_accept busy got %b want 1", busy); end
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin lat = c; break; end
      @(negedge clk);
    end
    tests++; if (lat != LAT || result !== 32'd25) begin
      fails++; $display("FAIL idle_start_result got %0d lat %0d want 25 lat %0d", result, lat, LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun;
    logic [31:0] r; int lat, bc, pulses; logic [3:0] c1;
    @(negedge clk);
    start = 1'b1; op = 2'd0; in_a = 32'd9; in_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrun_reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL midrun_reset_done got %b want 0", done); end
    tests++; if (result !== 32'd0) begin fails++; $display("FAIL midrun_reset_result got %h want 0", result); end
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL midrun_no_done got %0d active cycles want 0", pulses); end
    run_op(2'd0, 32'd3, 32'd5, r, lat, bc, c1);
    tests++; if (r !== 32'd15 || lat != LAT) begin
      fails++; $display("FAIL post_reset_mul got %0d lat %0d want 15 lat %0d", r, lat, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_divzero();
    test_back_to_back();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
